// File: rtl/stream_if_pkg.sv
// Shared constants and beat type for the valid/ready stream stages.
package stream_if_pkg;

    localparam int OCC_W     = 2;
    localparam int BUF_DEPTH = 2;
    localparam int BEAT_W    = 4;

    typedef struct packed {
        logic              valid;
        logic [BEAT_W-1:0] data;
    } stream_beat_t;

endpackage

// File: rtl/stream_skid_buf2.sv
// Two-entry circular output buffer with push/pop/flush and occupancy.
module stream_skid_buf2
    import stream_if_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [OCC_W-1:0] occupancy
);

    logic [WIDTH-1:0] mem [BUF_DEPTH];
    logic             wr_idx;
    logic             rd_idx;
    logic [OCC_W-1:0] occ;
    logic             pop_ok;

    assign pop_ok = pop && (occ != '0);

    // Storage is cleared on reset so the output word is never X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_idx <= 1'b0;
            rd_idx <= 1'b0;
            occ    <= '0;
        end else if (flush) begin
            wr_idx <= 1'b0;
            rd_idx <= 1'b0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_idx] <= push_data;
                wr_idx      <= ~wr_idx;
            end
            if (pop_ok) begin
                rd_idx <= ~rd_idx;
            end
            occ <= occ + {{(OCC_W-1){1'b0}}, push} - {{(OCC_W-1){1'b0}}, pop_ok};
        end
    end

    assign valid     = (occ != '0);
    assign data      = mem[rd_idx];
    assign occupancy = occ;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO read port onto a valid/ready stream, hiding read latency.
module fifo_stream_reader
    import stream_if_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [OCC_W-1:0] occupancy
);

    logic             inflight;
    logic             pop;
    logic [OCC_W:0]   credit_sum;

    assign pop = m_valid && m_ready;

    // Words held plus the word on its way must stay within the buffer depth.
    assign credit_sum = {1'b0, occupancy}
                      + {{OCC_W{1'b0}}, inflight}
                      - {{OCC_W{1'b0}}, pop};

    assign fifo_rd_en = !rst && !fifo_empty && !flush
                      && (credit_sum < (OCC_W+1)'(BUF_DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
        end
    end

    stream_skid_buf2 #(
        .WIDTH(WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (inflight && !flush),
        .push_data (fifo_data),
        .pop       (pop),
        .valid     (m_valid),
        .data      (m_data),
        .occupancy (occupancy)
    );

endmodule
